// File: rtl/filter_ctrl_pkg.sv
// filter_ctrl_pkg: shared types for the filter frame sequencer.
// Holds the state encoding and operation-unit output layout.
package filter_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam int VALID_BIT = 8;

endpackage

// File: rtl/filter_pos_counter.sv
// filter_pos_counter: column/row tracking of accepted pixels.
// Flags the last pixel of a frame and window-border pixels.
module filter_pos_counter #(
  parameter int Ope_Size    = 3,
  parameter int Width_Bits  = 11,
  parameter int Height_Bits = 11
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   step,
  input  logic [Width_Bits-1:0]  img_width,
  input  logic [Height_Bits-1:0] img_height,
  output logic [Width_Bits-1:0]  col,
  output logic [Height_Bits-1:0] row,
  output logic                   last,
  output logic                   border
);

  localparam logic [31:0] M = 32'(Ope_Size / 2);

  logic        col_end;
  logic [31:0] col32;
  logic [31:0] row32;
  logic [31:0] w32;
  logic [31:0] h32;

  assign col_end = (col == img_width - Width_Bits'(1));
  assign last    = col_end &&
                   (row == img_height - Height_Bits'(1));

  assign col32 = 32'(col);
  assign row32 = 32'(row);
  assign w32   = 32'(img_width);
  assign h32   = 32'(img_height);

  // "pos > dim-1-M" rewritten as "pos+M+1 > dim" so zero dims cannot underflow
  assign border = (col32 < M) ||
                  (col32 + M + 32'd1 > w32) ||
                  (row32 < M) ||
                  (row32 + M + 32'd1 > h32);

  // advance raster position on each accepted pixel
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      col <= '0;
      row <= '0;
    end else if (step) begin
      if (col_end) begin
        col <= '0;
        row <= row + Height_Bits'(1);
      end else begin
        col <= col + Width_Bits'(1);
      end
    end
  end

endmodule

// File: rtl/filter_frame_ctrl.sv
// filter_frame_ctrl: frame sequencer for the sliding-window filter.
// FILTER_CTRL_TIMEOUT_EN enables the DRAIN idle-output timeout.
module filter_frame_ctrl
  import filter_ctrl_pkg::*;
#(
  parameter int Ope_Size      = 3,
  parameter int Width_Bits    = 11,
  parameter int Height_Bits   = 11,
  parameter int Flush_Cycles  = 4,
  parameter int Drain_Timeout = 1024
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [Width_Bits-1:0]             img_width,
  input  logic [Height_Bits-1:0]            img_height,
  input  logic                              pix_in_valid,
  output logic                              pix_in_ready,
  input  logic [8:0]                        ope_out,
  output logic                              reflesh,
  output logic [Width_Bits-1:0]             cur_col,
  output logic [Height_Bits-1:0]            cur_row,
  output logic                              border,
  output logic [Width_Bits+Height_Bits-1:0] out_count,
  output logic                              busy,
  output logic                              done,
  output logic                              err
);

  localparam int CW = Width_Bits + Height_Bits;
  localparam int FW = $clog2(Flush_Cycles + 1);

  state_t                 state;
  state_t                 state_n;
  logic [Width_Bits-1:0]  w_q;
  logic [Width_Bits-1:0]  w_n;
  logic [Height_Bits-1:0] h_q;
  logic [Height_Bits-1:0] h_n;
  logic [FW-1:0]          flush_q;
  logic [FW-1:0]          flush_n;
  logic [CW-1:0]          cnt_n;
  logic [CW-1:0]          target;
  logic                   err_n;
  logic                   clr;
  logic                   step;
  logic                   last;
  logic                   res_vld;
  logic [7:0]             unused_pix;

  assign res_vld    = ope_out[VALID_BIT];
  assign unused_pix = ope_out[7:0];
  assign target     = CW'(w_q) * CW'(h_q);
  assign step       = pix_in_valid & pix_in_ready;

`ifdef FILTER_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(Drain_Timeout + 1);
  logic [TW-1:0] tmo_q;
  logic [TW-1:0] tmo_n;
`else
  localparam int unused_tmo = Drain_Timeout;
`endif

  filter_pos_counter #(
    .Ope_Size    (Ope_Size),
    .Width_Bits  (Width_Bits),
    .Height_Bits (Height_Bits)
  ) u_pos (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .step       (step),
    .img_width  (w_q),
    .img_height (h_q),
    .col        (cur_col),
    .row        (cur_row),
    .last       (last),
    .border     (border)
  );

  // next-state, counter and flag updates
  always_comb begin
    state_n = state;
    w_n     = w_q;
    h_n     = h_q;
    flush_n = flush_q;
    cnt_n   = out_count;
    err_n   = err;
    clr     = 1'b0;
`ifdef FILTER_CTRL_TIMEOUT_EN
    tmo_n   = tmo_q;
`endif
    if (res_vld && (state == RUN || state == DRAIN))
      cnt_n = out_count + CW'(1);
    unique case (state)
      IDLE: begin
        if (start) begin
          w_n     = img_width;
          h_n     = img_height;
          clr     = 1'b1;
          cnt_n   = '0;
          err_n   = 1'b0;
          flush_n = '0;
          if (img_width == '0 || img_height == '0) begin
            err_n   = 1'b1;
            state_n = DONE;
          end else begin
            state_n = CLEAR;
          end
        end
      end
      CLEAR: begin
        if (flush_q == FW'(Flush_Cycles - 1))
          state_n = RUN;
        else
          flush_n = flush_q + FW'(1);
      end
      RUN: begin
`ifdef FILTER_CTRL_TIMEOUT_EN
        tmo_n = '0;
`endif
        if (step && last)
          state_n = DRAIN;
      end
      DRAIN: begin
        if (cnt_n == target)
          state_n = DONE;
`ifdef FILTER_CTRL_TIMEOUT_EN
        else if (res_vld)
          tmo_n = '0;
        else if (tmo_q == TW'(Drain_Timeout - 1)) begin
          err_n   = 1'b1;
          state_n = DONE;
        end else
          tmo_n = tmo_q + TW'(1);
`endif
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // state register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      w_q          <= '0;
      h_q          <= '0;
      flush_q      <= '0;
      out_count    <= '0;
      err          <= 1'b0;
      pix_in_ready <= 1'b0;
      reflesh      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_n;
      w_q          <= w_n;
      h_q          <= h_n;
      flush_q      <= flush_n;
      out_count    <= cnt_n;
      err          <= err_n;
      pix_in_ready <= (state_n == RUN);
      reflesh      <= (state_n == CLEAR);
      busy         <= (state_n != IDLE);
      done         <= (state_n == DONE);
    end
  end

`ifdef FILTER_CTRL_TIMEOUT_EN
  // consecutive idle-output cycles while draining
  always_ff @(posedge clk) begin
    if (rst)
      tmo_q <= '0;
    else
      tmo_q <= tmo_n;
  end
`endif

endmodule

// File: tb/tb_filter_frame_ctrl.sv
// tb_filter_frame_ctrl: randomized scoreboard bench for filter_frame_ctrl.
// Build with FILTER_CTRL_TIMEOUT_EN to also cover the drain timeout.
module tb_filter_frame_ctrl;

  localparam int OPE = 3;
  localparam int WB  = 11;
  localparam int HB  = 11;
  localparam int FC  = 4;
  localparam int DT  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [WB-1:0] img_width;
  logic [HB-1:0] img_height;
  logic          pix_in_valid;
  logic          pix_in_ready;
  logic [8:0]    ope_out;
  logic          reflesh;
  logic [WB-1:0] cur_col;
  logic [HB-1:0] cur_row;
  logic          border;
  logic [WB+HB-1:0] out_count;
  logic          busy;
  logic          done;
  logic          err;

  filter_frame_ctrl #(
    .Ope_Size      (OPE),
    .Width_Bits    (WB),
    .Height_Bits   (HB),
    .Flush_Cycles  (FC),
    .Drain_Timeout (DT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .img_width    (img_width),
    .img_height   (img_height),
    .pix_in_valid (pix_in_valid),
    .pix_in_ready (pix_in_ready),
    .ope_out      (ope_out),
    .reflesh      (reflesh),
    .cur_col      (cur_col),
    .cur_row      (cur_row),
    .border       (border),
    .out_count    (out_count),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input bit ok, input string nm,
                       input longint act, input longint exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  typedef struct { int c; int r; bit b; } pix_t;
  typedef struct { int w; int h; int hold; int t; } frm_t;

  pix_t pq[$];
  frm_t fq[$];
  int   due[$];
  int   cur_area = 0;
  int   cur_hold = 0;
  int   emitted  = 0;
  int   last_res = -100;

  function automatic bit exp_border(int c, int r, int w, int h);
    int m;
    m = OPE / 2;
    return (c < m) || (c > w - 1 - m) ||
           (r < m) || (r > h - 1 - m);
  endfunction

  function automatic int exp_interior(int w, int h);
    int iw;
    int ih;
    iw = w - 2 * (OPE / 2);
    ih = h - 2 * (OPE / 2);
    if (iw < 0) iw = 0;
    if (ih < 0) ih = 0;
    return iw * ih;
  endfunction

  // operation unit model: a result two cycles after each pixel,
  // plus stray valids while the controller is idle or clearing
  initial begin
    bit v;
    ope_out = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        due.delete();
        ope_out = '0;
      end else begin
        v = 1'b0;
        if (due.size() > 0 && due[0] == cyc) begin
          void'(due.pop_front());
          v = 1'b1;
          last_res = cyc;
        end else if ((!busy || reflesh) &&
                     $urandom_range(0, 2) == 0) begin
          v = 1'b1;
        end
        ope_out = {v, 8'($urandom)};
        if (start && !busy) emitted = 0;
        if (pix_in_valid && pix_in_ready) begin
          if (emitted < cur_area - cur_hold)
            due.push_back(cyc + 2);
          emitted++;
        end
      end
    end
  end

  // monitor: compares DUT behaviour against queued expectations
  initial begin
    frm_t act;
    pix_t e;
    bit   have_act = 0;
    bit   prev_ref = 0;
    bit   prev_rdy = 0;
    bit   last_flag = 0;
    bit   done_flag = 0;
    bit   rst_seen = 0;
    int   ref_len = 0;
    int   last_pix = 0;
    int   interior = 0;
    int   area;
    int   x_cyc;
    int   x_cnt;
    int   x_err;
    forever begin
      @(negedge clk);
      if (rst_seen && !rst)
        check({busy, pix_in_ready, done, reflesh} == 4'b0 &&
              out_count == '0, "post_reset",
              {busy, pix_in_ready, done, reflesh}, 0);
      rst_seen = rst;
      if (rst) begin
        pq.delete();
        have_act  = 0;
        prev_ref  = 0;
        prev_rdy  = 0;
        last_flag = 0;
        done_flag = 0;
        ref_len   = 0;
        continue;
      end
      if (start && !busy) begin
        check(fq.size() > 0, "frame_queue", fq.size(), 1);
        if (fq.size() > 0) begin
          act = fq.pop_front();
          have_act = 1;
          interior = 0;
        end
      end
      if (reflesh && !prev_ref) begin
        check(have_act && act.w * act.h > 0 && cyc == act.t + 1,
              "reflesh_start", cyc, act.t + 1);
        ref_len = 0;
      end
      if (reflesh) begin
        ref_len++;
        check(out_count == '0, "clear_count", out_count, 0);
      end
      if (!reflesh && prev_ref)
        check(ref_len == FC, "reflesh_len", ref_len, FC);
      if (pix_in_ready && !prev_rdy)
        check(have_act && cyc == act.t + FC + 1,
              "ready_start", cyc, act.t + FC + 1);
      if (last_flag) begin
        check(!pix_in_ready, "ready_drop", pix_in_ready, 0);
        last_flag = 0;
      end
      if (done_flag) begin
        check(!done && !busy, "done_end", {done, busy}, 0);
        done_flag = 0;
      end
      if (pix_in_valid && pix_in_ready) begin
        check(pq.size() > 0, "pix_expected", pq.size(), 1);
        if (pq.size() > 0) begin
          e = pq.pop_front();
          check(cur_col == e.c, "cur_col", cur_col, e.c);
          check(cur_row == e.r, "cur_row", cur_row, e.r);
          check(border == e.b, "border", border, e.b);
          if (!border) interior++;
          if (pq.size() == 0) begin
            last_flag = 1;
            last_pix  = cyc;
          end
        end
      end
      if (done) begin
        check(have_act, "done_expected", 0, 1);
        if (have_act) begin
          area = act.w * act.h;
          if (area == 0) begin
            x_cyc = act.t + 1;
            x_cnt = 0;
            x_err = 1;
          end else if (act.hold > 0) begin
            x_cyc = last_pix + 1 + DT;
            x_cnt = area - act.hold;
            x_err = 1;
          end else begin
            x_cyc = last_res + 1;
            x_cnt = area;
            x_err = 0;
          end
          check(cyc == x_cyc, "done_cycle", cyc, x_cyc);
          check(out_count == x_cnt, "out_count", out_count, x_cnt);
          check(err == x_err, "err", err, x_err);
          check(pq.size() == 0, "pix_left", pq.size(), 0);
          check(interior == exp_interior(act.w, act.h),
                "interior", interior,
                exp_interior(act.w, act.h));
          have_act  = 0;
          done_flag = 1;
        end
      end
      prev_ref = reflesh;
      prev_rdy = pix_in_ready;
    end
  end

  task automatic run_frame(input int w, input int h,
                           input int hold, input int pct,
                           input bit mid, input int abort_at);
    frm_t f;
    int   acc = 0;
    bit   fin = 0;
    bit   mid_done = 0;
    int   k;
    cur_area = w * h;
    cur_hold = hold;
    f = '{w, h, hold, cyc};
    fq.push_back(f);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        pq.push_back('{c, r, exp_border(c, r, w, h)});
    img_width  = WB'(w);
    img_height = HB'(h);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (k = 0; k < 3000; k++) begin
      pix_in_valid = ($urandom_range(1, 100) <= pct);
      if (mid && acc == 3 && !mid_done) begin
        start      = 1'b1;
        img_width  = WB'($urandom_range(1, 9));
        img_height = HB'($urandom_range(1, 9));
        mid_done   = 1;
      end
      if (abort_at > 0 && acc == abort_at) begin
        pix_in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        fin = 1;
        break;
      end
      @(negedge clk);
      if (pix_in_valid && pix_in_ready) acc++;
      if (done) fin = 1;
      @(posedge clk); #1;
      start = 1'b0;
      if (fin) break;
    end
    pix_in_valid = 1'b0;
    check(fin, "frame_finished", k, 3000);
    if (!fin) begin
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    pix_in_valid = 1'b0;
    img_width    = '0;
    img_height   = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check({pix_in_ready, reflesh, busy, done, err} == 5'b0,
          "reset_flags", {pix_in_ready, reflesh, busy, done, err}, 0);
    check(cur_col == '0, "reset_col", cur_col, 0);
    check(cur_row == '0, "reset_row", cur_row, 0);
    check(out_count == '0, "reset_count", out_count, 0);
    check(border == exp_border(0, 0, 0, 0), "reset_border",
          border, exp_border(0, 0, 0, 0));
    repeat (3) @(posedge clk);
    #1;
    run_frame(4, 3, 0, 100, 0, 0);
    run_frame(5, 5, 0, 100, 0, 0);
    run_frame(0, 5, 0, 100, 0, 0);
    run_frame(3, 0, 0, 100, 0, 0);
    run_frame(1, 1, 0, 100, 0, 0);
    run_frame(1, 6, 0, 70, 0, 0);
    for (int i = 0; i < 6; i++)
      run_frame($urandom_range(1, 7), $urandom_range(1, 7),
                0, $urandom_range(40, 100), 0, 0);
    run_frame(4, 4, 0, 100, 1, 0);
    run_frame(6, 4, 0, 80, 0, 7);
    run_frame(3, 3, 0, 100, 0, 0);
`ifdef FILTER_CTRL_TIMEOUT_EN
    run_frame(4, 3, 3, 100, 0, 0);
    run_frame(5, 3, 0, 100, 0, 0);
`endif
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: got %0d cycles expected fewer", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/filter_frame_ctrl.md
# filter_frame_ctrl

Frame-level sequencer for the sliding-window filter datapath. Clears the line buffer and operation unit with `reflesh`, gates upstream pixel entry, tracks the column/row of every accepted pixel (with a window border flag), and counts valid results on the operation unit's 9-bit output. Sits between the host start/done handshake and the window-buffer/operation pair; one instance per filter pipeline.

## Interface
- `Ope_Size`, 3: window edge length (odd); border margin is `Ope_Size/2`.
- `Width_Bits`, 11: width of the `img_width` port and of the column counter.
- `Height_Bits`, 11: width of the `img_height` port and of the row counter.
- `Flush_Cycles`, 4: number of cycles `reflesh` is held (≥1).
- `Drain_Timeout`, 1024: idle-output cycles before DRAIN gives up (used only with the macro).
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, synchronous and active-high; returns the block to IDLE from any state.
- `start`  in  1  frame request; accepted only in IDLE.
- `img_width`  in  Width_Bits  pixels per line; sampled on start acceptance.
- `img_height`  in  Height_Bits  lines per frame; sampled on start acceptance.
- `pix_in_valid`  in  1  upstream pixel strobe.
- `pix_in_ready`  out  1  pixel accepted when `pix_in_valid & pix_in_ready`.
- `ope_out`  in  9  operation unit output; bit 8 = valid, bits 7:0 = pixel (ignored).
- `reflesh`  out  1  clear to line buffer and operation unit.
- `cur_col`  out  Width_Bits  column of the pixel offered this cycle.
- `cur_row`  out  Height_Bits  row of the pixel offered this cycle.
- `border`  out  1  offered pixel lies within `Ope_Size/2` of any edge.
- `out_count`  out  Width_Bits+Height_Bits  valid results counted this frame.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse at end of frame.
- `err`  out  1  sticky frame error; cleared on next accepted start.

## Operation
- States: IDLE, CLEAR, RUN, DRAIN, DONE.
- IDLE: `start=1` → latch dims, clear counters, `out_count`, and `err`. If either dim is 0: set `err`, go DONE (no `reflesh`). Otherwise go CLEAR.
- CLEAR: `reflesh=1` for exactly `Flush_Cycles` cycles, then RUN.
- RUN: `pix_in_ready=1`. Each accepted pixel increments `cur_col`; at `img_width-1` it wraps to 0 and `cur_row` increments. Accepting pixel (`img_height-1`, `img_width-1`) → DRAIN.
- DRAIN: `pix_in_ready=0`. Leave for DONE in the cycle where the next value of `out_count` equals `img_width*img_height`.
- DONE: `done=1` for one cycle, then IDLE.
- Result counting: `out_count` increments on `ope_out[8]` in RUN and DRAIN only. It is ignored in IDLE, CLEAR and DONE. Expected count is the full-width product `img_width*img_height`, with no truncation.
- `border` = `cur_col < M` or `cur_col > img_width-1-M` or `cur_row < M` or `cur_row > img_height-1-M`, where `M = Ope_Size/2`. Combinational from counters and latched dims.
- `start` outside IDLE is ignored. `rst` mid-frame: all state abandoned, no `done` pulse.
- An accepted last pixel and an output valid in the same cycle are both applied.

## Timing
- Reset values: `pix_in_ready=0`, `reflesh=0`, `cur_col=0`, `cur_row=0`, `out_count=0`, `busy=0`, `done=0`, `err=0`.
- `border` after reset follows its formula; dims reset to 0.
- All outputs are registered except `border`.
- `start` accepted at cycle T → `reflesh=1` on T+1..T+Flush_Cycles → `pix_in_ready=1` from T+Flush_Cycles+1.
- Last pixel accepted at cycle L → `pix_in_ready=0` at L+1.
- Final result valid at cycle R → `done=1` at R+1 and `busy=0` at R+2.
- Zero dimension: `done=1` and `err=1` at T+1.

## Configuration
- `FILTER_CTRL_TIMEOUT_EN` defined: DRAIN counts consecutive cycles without `ope_out[8]`. After `Drain_Timeout` such cycles it sets `err=1` and goes DONE. The counter resets on every valid result.
- `FILTER_CTRL_TIMEOUT_EN` undefined: DRAIN waits indefinitely and the `Drain_Timeout` parameter is unused.

## Structure
- Package `filter_ctrl_pkg`: state enum (IDLE/CLEAR/RUN/DRAIN/DONE) and the valid-bit index constant (8).
- Sub-module `filter_pos_counter`: col/row counters with wrap, last-pixel flag, and border computation.

## Test plan
- Dims 4×3, `Flush_Cycles=4`, continuous `pix_in_valid`, results returned 2 cycles after each input → `reflesh` high 4 cycles; 12 pixels accepted; `done` 1 cycle after 12th result; `out_count=12`; `err=0`.
- Dims 5×5, `Ope_Size=3` → `border=0` only for col,row ∈ {1..3}, i.e. 9 interior pixels; 16 border pixels.
- `img_width=0` → `done` at T+1, `err=1`, `reflesh` never asserted.
- `start` pulsed during RUN; `rst` asserted mid-RUN → first ignored; after `rst`, next cycle `busy=0`, `pix_in_ready=0`, no `done`.
- With the macro, `Drain_Timeout=8`, withhold the last 3 results → `err=1`, `done` after 8 idle DRAIN cycles, `out_count=N-3`.
- `ope_out[8]` pulsed in IDLE and CLEAR → `out_count` stays 0.
